// File: rtl/my_riscv_core_ahb_pkg.sv
// Shared AHB encodings for the L1 bus matrix input stage.
//   - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
//   - HBURST INCR encoding
//   - HRESP OKAY/ERROR encodings
//   - Input-stage FSM state type
package my_riscv_core_ahb_pkg;

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransBusy   = 2'b01;
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;

    localparam logic [2:0] BurstIncr   = 3'b001;

    localparam logic [1:0] RespOkay    = 2'b00;
    localparam logic [1:0] RespError   = 2'b01;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StPend = 2'b01,
        StData = 2'b10
    } in_state_e;

endpackage

// File: rtl/my_riscv_core_input_stage.sv
// Per-master AHB input stage of the L1 bus matrix.
// Captures every accepted address phase. If the target output stage does not
// take it in the same cycle, the transfer is held and the master is stalled
// until active_trans arrives.
// Ports:
//   HCLK, HRESET            clock, synchronous active-high reset
//   HSELS..HMASTLOCKS       master-side address/control
//   HREADYS                 bus-level ready (address phase accepted when high)
//   active_trans            output stage takes our address phase this cycle
//   HREADYM_d, HRESPM_d     data-phase ready/response from owning output stage
//   HSELI..HMASTLOCKI       live or held address/control to decoder/arbiters
//   trans_pend              a held transfer is waiting for grant
//   HREADYOUTS, HRESPS      data-phase ready/response to the master
module my_riscv_core_input_stage
    import my_riscv_core_ahb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [3:0]            HPROTS,
    input  logic                  HMASTLOCKS,
    input  logic                  HREADYS,
    input  logic                  active_trans,
    input  logic                  HREADYM_d,
    input  logic [1:0]            HRESPM_d,
    output logic                  HSELI,
    output logic [ADDR_WIDTH-1:0] HADDRI,
    output logic [1:0]            HTRANSI,
    output logic                  HWRITEI,
    output logic [2:0]            HSIZEI,
    output logic [2:0]            HBURSTI,
    output logic [3:0]            HPROTI,
    output logic                  HMASTLOCKI,
    output logic                  trans_pend,
    output logic                  HREADYOUTS,
    output logic [1:0]            HRESPS
);

    logic trans_req;
    logic new_trans;

    assign trans_req = HSELS & HTRANSS[1];
    assign new_trans = trans_req & HREADYS;

    in_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            trans_q, trans_d;
    logic                  write_q, write_d;
    logic [2:0]            size_q, size_d;
    logic [2:0]            burst_q, burst_d;
    logic [3:0]            prot_q, prot_d;
    logic                  lock_q, lock_d;

    // Holding register: loaded on every accepted address phase, otherwise kept.
    always_comb begin
        addr_d  = addr_q;
        trans_d = trans_q;
        write_d = write_q;
        size_d  = size_q;
        burst_d = burst_q;
        prot_d  = prot_q;
        lock_d  = lock_q;
        if (new_trans) begin
            addr_d  = HADDRS;
            trans_d = HTRANSS;
            write_d = HWRITES;
            size_d  = HSIZES;
            burst_d = HBURSTS;
            prot_d  = HPROTS;
            lock_d  = HMASTLOCKS;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (new_trans) begin
                    state_d = active_trans ? StData : StPend;
                end
            end
            StPend: begin
                if (active_trans) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (HREADYM_d) begin
                    if (new_trans) begin
                        state_d = active_trans ? StData : StPend;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= StIdle;
            addr_q  <= '0;
            trans_q <= TransIdle;
            write_q <= 1'b0;
            size_q  <= 3'b000;
            burst_q <= 3'b000;
            prot_q  <= 4'b0000;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            trans_q <= trans_d;
            write_q <= write_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            prot_q  <= prot_d;
            lock_q  <= lock_d;
        end
    end

    always_comb begin
        HSELI      = HSELS;
        HADDRI     = HADDRS;
        HTRANSI    = HSELS ? HTRANSS : TransIdle;
        HWRITEI    = HWRITES;
        HSIZEI     = HSIZES;
        HBURSTI    = HBURSTS;
        HPROTI     = HPROTS;
        HMASTLOCKI = HMASTLOCKS;
        trans_pend = 1'b0;
        HREADYOUTS = 1'b1;
        HRESPS     = RespOkay;
        unique case (state_q)
            StPend: begin
                // A held transfer is re-issued as the start of a fresh burst,
                // since the arbiter may have serviced others in between.
                HSELI      = 1'b1;
                HADDRI     = addr_q;
                HTRANSI    = TransNonseq;
                HWRITEI    = write_q;
                HSIZEI     = size_q;
                HBURSTI    = (trans_q == TransSeq) ? BurstIncr : burst_q;
                HPROTI     = prot_q;
                HMASTLOCKI = lock_q;
                trans_pend = 1'b1;
                HREADYOUTS = 1'b0;
            end
            StData: begin
                HREADYOUTS = HREADYM_d;
                HRESPS     = HRESPM_d;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_my_riscv_core_input_stage.sv
// Self-checking bench for my_riscv_core_input_stage: a table of per-cycle
// input vectors with hand-derived expected outputs. Each row's expectation is
// queued when the row is driven and popped when outputs are sampled.
module tb_my_riscv_core_input_stage;

    typedef struct packed {
        logic        rst;
        logic        sel;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic        lock;
        logic        hready;
        logic        act;
        logic        hrm;
        logic [1:0]  hrsp;
    } in_t;

    typedef struct packed {
        logic        sel;
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic        lock;
        logic        pend;
        logic        rdy;
        logic [1:0]  resp;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    localparam int NumVec = 28;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic        HMASTLOCKS;
    logic        HREADYS;
    logic        active_trans;
    logic        HREADYM_d;
    logic [1:0]  HRESPM_d;
    logic        HSELI;
    logic [31:0] HADDRI;
    logic [1:0]  HTRANSI;
    logic        HWRITEI;
    logic [2:0]  HSIZEI;
    logic [2:0]  HBURSTI;
    logic [3:0]  HPROTI;
    logic        HMASTLOCKI;
    logic        trans_pend;
    logic        HREADYOUTS;
    logic [1:0]  HRESPS;

    always #5 HCLK = ~HCLK;

    my_riscv_core_input_stage #(
        .ADDR_WIDTH(32)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HSELS       (HSELS),
        .HADDRS      (HADDRS),
        .HTRANSS     (HTRANSS),
        .HWRITES     (HWRITES),
        .HSIZES      (HSIZES),
        .HBURSTS     (HBURSTS),
        .HPROTS      (HPROTS),
        .HMASTLOCKS  (HMASTLOCKS),
        .HREADYS     (HREADYS),
        .active_trans(active_trans),
        .HREADYM_d   (HREADYM_d),
        .HRESPM_d    (HRESPM_d),
        .HSELI       (HSELI),
        .HADDRI      (HADDRI),
        .HTRANSI     (HTRANSI),
        .HWRITEI     (HWRITEI),
        .HSIZEI      (HSIZEI),
        .HBURSTI     (HBURSTI),
        .HPROTI      (HPROTI),
        .HMASTLOCKI  (HMASTLOCKI),
        .trans_pend  (trans_pend),
        .HREADYOUTS  (HREADYOUTS),
        .HRESPS      (HRESPS)
    );

    function automatic in_t mk_in(input logic rst, input logic sel, input logic [31:0] addr,
                                  input logic [1:0] trans, input logic write,
                                  input logic [2:0] size, input logic [2:0] burst,
                                  input logic [3:0] prot, input logic lock,
                                  input logic hready, input logic act, input logic hrm,
                                  input logic [1:0] hrsp);
        in_t r;
        r = '{rst, sel, addr, trans, write, size, burst, prot, lock, hready, act, hrm, hrsp};
        return r;
    endfunction

    function automatic out_t mk_out(input logic sel, input logic [31:0] addr,
                                    input logic [1:0] trans, input logic write,
                                    input logic [2:0] size, input logic [2:0] burst,
                                    input logic [3:0] prot, input logic lock,
                                    input logic pend, input logic rdy, input logic [1:0] resp);
        out_t r;
        r = '{sel, addr, trans, write, size, burst, prot, lock, pend, rdy, resp};
        return r;
    endfunction

    // Master idle with bus ready; live outputs then show an unselected IDLE.
    function automatic in_t in_idle(input logic rst, input logic hrm, input logic [1:0] hrsp);
        return mk_in(rst, 1'b0, 32'h0, 2'b00, 1'b0, 3'd0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0,
                     hrm, hrsp);
    endfunction

    // Master stalled (HREADYS low) with live inputs driven to zero, so any
    // non-zero I-output can only come from the holding register.
    function automatic in_t in_stall(input logic rst, input logic act);
        return mk_in(rst, 1'b0, 32'h0, 2'b00, 1'b0, 3'd0, 3'd0, 4'd0, 1'b0, 1'b0, act,
                     1'b1, 2'b00);
    endfunction

    function automatic out_t out_idle(input logic rdy, input logic [1:0] resp);
        return mk_out(1'b0, 32'h0, 2'b00, 1'b0, 3'd0, 3'd0, 4'd0, 1'b0, 1'b0, rdy, resp);
    endfunction

    vec_t vecs [NumVec];
    vec_t exp_q [$];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic drive(input in_t v);
        HRESET       = v.rst;
        HSELS        = v.sel;
        HADDRS       = v.addr;
        HTRANSS      = v.trans;
        HWRITES      = v.write;
        HSIZES       = v.size;
        HBURSTS      = v.burst;
        HPROTS       = v.prot;
        HMASTLOCKS   = v.lock;
        HREADYS      = v.hready;
        active_trans = v.act;
        HREADYM_d    = v.hrm;
        HRESPM_d     = v.hrsp;
    endtask

    initial begin
        vec_t e;
        out_t act_o;

        // T1: granted in the same cycle, one wait state, then completes.
        vecs[0]  = '{in_idle(1, 1, 2'b00), out_idle(1, 2'b00)};
        vecs[1]  = '{mk_in(0, 1, 32'h2000_0000, 2'b10, 1, 3'd2, 3'd0, 4'h3, 0, 1, 1, 1, 2'b00),
                     mk_out(1, 32'h2000_0000, 2'b10, 1, 3'd2, 3'd0, 4'h3, 0, 0, 1, 2'b00)};
        vecs[2]  = '{in_idle(0, 0, 2'b00), out_idle(0, 2'b00)};
        vecs[3]  = '{in_idle(0, 1, 2'b00), out_idle(1, 2'b00)};
        // T2: not granted, held for several cycles, then granted.
        vecs[4]  = '{mk_in(0, 1, 32'h4000_0010, 2'b10, 0, 3'd1, 3'd0, 4'h2, 1, 1, 0, 1, 2'b00),
                     mk_out(1, 32'h4000_0010, 2'b10, 0, 3'd1, 3'd0, 4'h2, 1, 0, 1, 2'b00)};
        vecs[5]  = '{in_stall(0, 0),
                     mk_out(1, 32'h4000_0010, 2'b10, 0, 3'd1, 3'd0, 4'h2, 1, 1, 0, 2'b00)};
        vecs[6]  = vecs[5];
        vecs[7]  = vecs[5];
        vecs[8]  = '{in_stall(0, 1),
                     mk_out(1, 32'h4000_0010, 2'b10, 0, 3'd1, 3'd0, 4'h2, 1, 1, 0, 2'b00)};
        vecs[9]  = '{in_idle(0, 1, 2'b00), out_idle(1, 2'b00)};
        // T3: held SEQ/INCR4 re-issued as NONSEQ/INCR.
        vecs[10] = '{mk_in(0, 1, 32'h0000_1004, 2'b11, 1, 3'd2, 3'b011, 4'h1, 0, 1, 0, 1, 2'b00),
                     mk_out(1, 32'h0000_1004, 2'b11, 1, 3'd2, 3'b011, 4'h1, 0, 0, 1, 2'b00)};
        vecs[11] = '{in_stall(0, 0),
                     mk_out(1, 32'h0000_1004, 2'b10, 1, 3'd2, 3'b001, 4'h1, 0, 1, 0, 2'b00)};
        vecs[12] = '{in_stall(0, 1),
                     mk_out(1, 32'h0000_1004, 2'b10, 1, 3'd2, 3'b001, 4'h1, 0, 1, 0, 2'b00)};
        // T4: data phase completes while an ungranted NONSEQ arrives -> PEND.
        vecs[13] = '{mk_in(0, 1, 32'h3000_0020, 2'b10, 0, 3'd2, 3'd0, 4'h3, 0, 1, 0, 1, 2'b00),
                     mk_out(1, 32'h3000_0020, 2'b10, 0, 3'd2, 3'd0, 4'h3, 0, 0, 1, 2'b00)};
        vecs[14] = '{in_stall(0, 0),
                     mk_out(1, 32'h3000_0020, 2'b10, 0, 3'd2, 3'd0, 4'h3, 0, 1, 0, 2'b00)};
        vecs[15] = '{in_stall(0, 1),
                     mk_out(1, 32'h3000_0020, 2'b10, 0, 3'd2, 3'd0, 4'h3, 0, 1, 0, 2'b00)};
        // T5: two-cycle ERROR response passes through.
        vecs[16] = '{in_idle(0, 0, 2'b01), out_idle(0, 2'b01)};
        vecs[17] = '{in_idle(0, 1, 2'b01), out_idle(1, 2'b01)};
        // IDLE masks HRESPM_d; HSELS low forces HTRANSI to IDLE.
        vecs[18] = '{mk_in(0, 0, 32'h0, 2'b10, 0, 3'd0, 3'd0, 4'h0, 0, 1, 0, 1, 2'b01),
                     out_idle(1, 2'b00)};
        // T6: reset while pending.
        vecs[19] = '{mk_in(0, 1, 32'h5000_0000, 2'b10, 1, 3'd0, 3'd0, 4'h0, 0, 1, 0, 1, 2'b00),
                     mk_out(1, 32'h5000_0000, 2'b10, 1, 3'd0, 3'd0, 4'h0, 0, 0, 1, 2'b00)};
        vecs[20] = '{in_stall(1, 0),
                     mk_out(1, 32'h5000_0000, 2'b10, 1, 3'd0, 3'd0, 4'h0, 0, 1, 0, 2'b00)};
        vecs[21] = '{in_idle(0, 1, 2'b00), out_idle(1, 2'b00)};
        // Back-to-back granted transfers stay in DATA.
        vecs[22] = '{mk_in(0, 1, 32'h6000_0000, 2'b10, 0, 3'd2, 3'd0, 4'h0, 0, 1, 1, 1, 2'b00),
                     mk_out(1, 32'h6000_0000, 2'b10, 0, 3'd2, 3'd0, 4'h0, 0, 0, 1, 2'b00)};
        vecs[23] = '{mk_in(0, 1, 32'h6000_0004, 2'b11, 0, 3'd2, 3'd0, 4'h0, 0, 1, 1, 1, 2'b00),
                     mk_out(1, 32'h6000_0004, 2'b11, 0, 3'd2, 3'd0, 4'h0, 0, 0, 1, 2'b00)};
        vecs[24] = '{in_idle(0, 0, 2'b00), out_idle(0, 2'b00)};
        // Reset mid-DATA aborts: afterwards the stage reports ready/OKAY.
        vecs[25] = '{in_idle(0, 1, 2'b00), out_idle(1, 2'b00)};
        vecs[26] = '{mk_in(0, 1, 32'h7000_0000, 2'b10, 1, 3'd2, 3'd0, 4'h0, 0, 1, 1, 1, 2'b00),
                     mk_out(1, 32'h7000_0000, 2'b10, 1, 3'd2, 3'd0, 4'h0, 0, 0, 1, 2'b00)};
        vecs[27] = '{in_idle(1, 0, 2'b01), out_idle(0, 2'b01)};

        drive(in_idle(1, 1, 2'b00));
        repeat (2) @(posedge HCLK);

        for (int k = 0; k < NumVec; k++) begin
            @(posedge HCLK);
            #1;
            drive(vecs[k].i);
            exp_q.push_back(vecs[k]);
            #5;
            e = exp_q.pop_front();
            act_o = '{HSELI, HADDRI, HTRANSI, HWRITEI, HSIZEI, HBURSTI, HPROTI, HMASTLOCKI,
                      trans_pend, HREADYOUTS, HRESPS};
            n_checks++;
            if (act_o === e.o) begin
                n_pass++;
            end else begin
                $display("FAIL row%0d: got sel=%b addr=%h trans=%b wr=%b size=%0d burst=%b prot=%h lock=%b pend=%b rdy=%b resp=%b, want sel=%b addr=%h trans=%b wr=%b size=%0d burst=%b prot=%h lock=%b pend=%b rdy=%b resp=%b",
                         k, act_o.sel, act_o.addr, act_o.trans, act_o.write, act_o.size,
                         act_o.burst, act_o.prot, act_o.lock, act_o.pend, act_o.rdy,
                         act_o.resp, e.o.sel, e.o.addr, e.o.trans, e.o.write, e.o.size,
                         e.o.burst, e.o.prot, e.o.lock, e.o.pend, e.o.rdy, e.o.resp);
            end
        end

        // Final state after reset in row 27 must be IDLE.
        @(posedge HCLK);
        #1;
        drive(in_idle(0, 0, 2'b01));
        #5;
        n_checks++;
        if (HREADYOUTS === 1'b1 && HRESPS === 2'b00 && trans_pend === 1'b0) begin
            n_pass++;
        end else begin
            $display("FAIL post_reset_idle: got rdy=%b resp=%b pend=%b, want rdy=1 resp=00 pend=0",
                     HREADYOUTS, HRESPS, trans_pend);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
